mem_arbiter: RTL and testbench

- Upstream stage of the ram controller. Merges two CPU-side requesters onto the single ram request/response port: m0 is instruction fetch, m1 is load/store.
- Round-robin arbitration with one outstanding transaction at a time.
- Rejects misaligned accesses locally without touching ram.
- Guards against a hung ram with a response-timeout counter that returns an error.

---
 rtl/mem_pkg.sv | 22 ++
 rtl/rr_arb2.sv | 41 ++++
 rtl/mem_arbiter.sv | 148 ++++++++++++++
 tb/tb_mem_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared state encoding, owner ids and default widths for the ram-side request arbiter.
package mem_pkg;

    localparam int ADDR_W_DEF  = 32;
    localparam int DATA_W_DEF  = 32;
    localparam int TIMEOUT_DEF = 64;

    localparam logic M_FETCH = 1'b0;
    localparam logic M_LSU   = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        ERR   = 2'd3
    } state_t;

    function automatic logic is_aligned(input logic [1:0] addr_lsb);
        return addr_lsb == 2'b00;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin picker; grants are combinational, zero latency, and only while en is high.
// The priority flop hands preference to the non-owner whenever a transaction completes (flip).
module rr_arb2
    import mem_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic req0,
    input  logic req1,
    input  logic flip,
    input  logic owner,
    output logic gnt0,
    output logic gnt1
);

    logic prio;

    always_ff @(posedge clk) begin
        if (!rst) begin
            prio <= M_FETCH;
        end else if (flip) begin
            prio <= ~owner;
        end
    end

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (en) begin
            if (req0 && req1) begin
                gnt0 = (prio == M_FETCH);
                gnt1 = (prio == M_LSU);
            end else begin
                gnt0 = req0;
                gnt1 = req1;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Merges fetch (m0) and load/store (m1) onto one ram port, one transaction in flight, round-robin.
// Latency accept->ram_req 1 cycle, ram_rsp->mN_rsp 1 cycle; requesters stall (ready low) until the response.
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                m0_req_valid,
    output logic                m0_req_ready,
    input  logic [ADDR_W-1:0]   m0_req_addr,
    input  logic [DATA_W-1:0]   m0_req_wdata,
    input  logic                m0_req_we,
    input  logic [DATA_W/8-1:0] m0_req_be,
    output logic                m0_rsp_valid,
    output logic [DATA_W-1:0]   m0_rsp_rdata,
    output logic                m0_rsp_err,

    input  logic                m1_req_valid,
    output logic                m1_req_ready,
    input  logic [ADDR_W-1:0]   m1_req_addr,
    input  logic [DATA_W-1:0]   m1_req_wdata,
    input  logic                m1_req_we,
    input  logic [DATA_W/8-1:0] m1_req_be,
    output logic                m1_rsp_valid,
    output logic [DATA_W-1:0]   m1_rsp_rdata,
    output logic                m1_rsp_err,

    output logic                ram_req_valid,
    input  logic                ram_req_ready,
    output logic [ADDR_W-1:0]   ram_addr,
    output logic [DATA_W-1:0]   ram_wdata,
    output logic                ram_we,
    output logic [DATA_W/8-1:0] ram_be,
    input  logic                ram_rsp_valid,
    input  logic [DATA_W-1:0]   ram_rsp_rdata
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_t             state;
    logic               owner;
    logic [CNT_W-1:0]   cnt;

    logic               gnt0;
    logic               gnt1;
    logic               accept;
    logic [ADDR_W-1:0]  sel_addr;
    logic               busy;
    logic               timeout_hit;
    logic               done_ok;
    logic               rsp_fire;
    logic               rsp_err_nxt;
    logic [DATA_W-1:0]  rsp_rdata_nxt;

    // rst gates the grant so nothing is accepted while reset is held
    rr_arb2 u_arb (
        .clk   (clk),
        .rst   (rst),
        .en    (rst && (state == IDLE)),
        .req0  (m0_req_valid),
        .req1  (m1_req_valid),
        .flip  (rsp_fire),
        .owner (owner),
        .gnt0  (gnt0),
        .gnt1  (gnt1)
    );

    assign m0_req_ready  = gnt0;
    assign m1_req_ready  = gnt1;
    assign accept        = gnt0 || gnt1;
    assign sel_addr      = gnt1 ? m1_req_addr : m0_req_addr;
    assign ram_req_valid = (state == ISSUE);

    assign busy          = (state == ISSUE) || (state == WAIT);
    assign timeout_hit   = (cnt == CNT_W'(TIMEOUT - 1));
    // a ram completion in the timeout cycle still counts as a normal response
    assign done_ok       = (state == WAIT) && ram_rsp_valid;
    assign rsp_fire      = done_ok || (state == ERR) || (busy && timeout_hit);
    assign rsp_err_nxt   = !done_ok;
    assign rsp_rdata_nxt = (done_ok && !ram_we) ? ram_rsp_rdata : '0;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            owner        <= M_FETCH;
            cnt          <= '0;
            ram_addr     <= '0;
            ram_wdata    <= '0;
            ram_we       <= 1'b0;
            ram_be       <= '0;
            m0_rsp_valid <= 1'b0;
            m0_rsp_err   <= 1'b0;
            m0_rsp_rdata <= '0;
            m1_rsp_valid <= 1'b0;
            m1_rsp_err   <= 1'b0;
            m1_rsp_rdata <= '0;
        end else begin
            m0_rsp_valid <= 1'b0;
            m1_rsp_valid <= 1'b0;

            case (state)
                IDLE: begin
                    if (accept) begin
                        owner     <= gnt1 ? M_LSU : M_FETCH;
                        cnt       <= '0;
                        ram_addr  <= sel_addr;
                        ram_wdata <= gnt1 ? m1_req_wdata : m0_req_wdata;
                        ram_we    <= gnt1 ? m1_req_we    : m0_req_we;
                        ram_be    <= gnt1 ? m1_req_be    : m0_req_be;
                        state     <= is_aligned(sel_addr[1:0]) ? ISSUE : ERR;
                    end
                end
                ISSUE, WAIT: begin
                    cnt <= cnt + CNT_W'(1);
                    if (rsp_fire) begin
                        state <= IDLE;
                    end else if ((state == ISSUE) && ram_req_ready) begin
                        state <= WAIT;
                    end
                end
                ERR: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            if (rsp_fire) begin
                if (owner == M_LSU) begin
                    m1_rsp_valid <= 1'b1;
                    m1_rsp_err   <= rsp_err_nxt;
                    m1_rsp_rdata <= rsp_rdata_nxt;
                end else begin
                    m0_rsp_valid <= 1'b1;
                    m0_rsp_err   <= rsp_err_nxt;
                    m0_rsp_rdata <= rsp_rdata_nxt;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed scenarios plus randomized traffic, checked each cycle against a transaction-level model.
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = DW / 8;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          m0_req_valid, m1_req_valid;
    logic          m0_req_ready, m1_req_ready;
    logic [AW-1:0] m0_req_addr, m1_req_addr;
    logic [DW-1:0] m0_req_wdata, m1_req_wdata;
    logic          m0_req_we, m1_req_we;
    logic [BW-1:0] m0_req_be, m1_req_be;
    logic          m0_rsp_valid, m1_rsp_valid;
    logic [DW-1:0] m0_rsp_rdata, m1_rsp_rdata;
    logic          m0_rsp_err, m1_rsp_err;
    logic          ram_req_valid, ram_req_ready;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic          ram_we;
    logic [BW-1:0] ram_be;
    logic          ram_rsp_valid;
    logic [DW-1:0] ram_rsp_rdata;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready), .m0_req_addr(m0_req_addr),
        .m0_req_wdata(m0_req_wdata), .m0_req_we(m0_req_we), .m0_req_be(m0_req_be),
        .m0_rsp_valid(m0_rsp_valid), .m0_rsp_rdata(m0_rsp_rdata), .m0_rsp_err(m0_rsp_err),
        .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready), .m1_req_addr(m1_req_addr),
        .m1_req_wdata(m1_req_wdata), .m1_req_we(m1_req_we), .m1_req_be(m1_req_be),
        .m1_rsp_valid(m1_rsp_valid), .m1_rsp_rdata(m1_rsp_rdata), .m1_rsp_err(m1_rsp_err),
        .ram_req_valid(ram_req_valid), .ram_req_ready(ram_req_ready), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_be(ram_be),
        .ram_rsp_valid(ram_rsp_valid), .ram_rsp_rdata(ram_rsp_rdata)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;
    int cyc    = 0;

    // Model: at most one transaction in flight, described by its fields and accept cycle.
    logic          busy = 1'b0;
    logic          issued = 1'b0;
    logic          prio = 1'b0;
    logic          t_owner = 1'b0;
    logic [AW-1:0] t_addr = '0;
    logic [DW-1:0] t_wdata = '0;
    logic          t_we = 1'b0;
    logic [BW-1:0] t_be = '0;
    int            acc_cyc = 0;
    logic          mv[2];
    logic          me[2];
    logic [DW-1:0] md[2];

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, got, exp);
        end else begin
            passed++;
        end
    endtask

    task automatic drive_zero();
        m0_req_valid = 0; m0_req_addr = '0; m0_req_wdata = '0; m0_req_we = 0; m0_req_be = '0;
        m1_req_valid = 0; m1_req_addr = '0; m1_req_wdata = '0; m1_req_we = 0; m1_req_be = '0;
        ram_req_ready = 0; ram_rsp_valid = 0; ram_rsp_rdata = '0;
    endtask

    // Compare this cycle's outputs with the model, advance the model across the edge, step the clock.
    task automatic tick();
        logic er0, er1, eram, ok, done, al;
        int age;
        int o;
        #2;
        al   = (t_addr[1:0] == 2'b00);
        er0  = rst && !busy && m0_req_valid && (!m1_req_valid || prio == 1'b0);
        er1  = rst && !busy && m1_req_valid && (!m0_req_valid || prio == 1'b1);
        eram = busy && al && !issued;
        chk("m0_req_ready", m0_req_ready, er0);
        chk("m1_req_ready", m1_req_ready, er1);
        chk("ram_req_valid", ram_req_valid, eram);
        if (eram) begin
            chk("ram_addr", ram_addr, t_addr);
            chk("ram_wdata", ram_wdata, t_wdata);
            chk("ram_we", ram_we, t_we);
            chk("ram_be", ram_be, t_be);
        end
        chk("m0_rsp_valid", m0_rsp_valid, mv[0]);
        chk("m0_rsp_err", m0_rsp_err, me[0]);
        chk("m0_rsp_rdata", m0_rsp_rdata, md[0]);
        chk("m1_rsp_valid", m1_rsp_valid, mv[1]);
        chk("m1_rsp_err", m1_rsp_err, me[1]);
        chk("m1_rsp_rdata", m1_rsp_rdata, md[1]);

        if (!rst) begin
            busy = 0; issued = 0; prio = 0;
            for (int i = 0; i < 2; i++) begin
                mv[i] = 0; me[i] = 0; md[i] = '0;
            end
        end else begin
            mv[0] = 0;
            mv[1] = 0;
            if (busy) begin
                age  = cyc - acc_cyc;
                ok   = al && issued && ram_rsp_valid;
                done = ok || !al || (age >= TO);
                if (done) begin
                    o     = t_owner ? 1 : 0;
                    mv[o] = 1;
                    me[o] = !ok;
                    md[o] = (ok && !t_we) ? ram_rsp_rdata : '0;
                    prio  = !t_owner;
                    busy  = 0;
                end else if (!issued && ram_req_ready) begin
                    issued = 1;
                end
            end else if (er0 || er1) begin
                t_owner = er1;
                t_addr  = er1 ? m1_req_addr  : m0_req_addr;
                t_wdata = er1 ? m1_req_wdata : m0_req_wdata;
                t_we    = er1 ? m1_req_we    : m0_req_we;
                t_be    = er1 ? m1_req_be    : m0_req_be;
                acc_cyc = cyc;
                busy    = 1;
                issued  = 0;
            end
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d got=running exp=finished", cyc);
        $fatal(1);
    end

    initial begin
        int gq[$];
        logic dead;
        logic [AW-1:0] a;
        for (int i = 0; i < 2; i++) begin
            mv[i] = 0; me[i] = 0; md[i] = '0;
        end
        drive_zero();
        rst = 0;
        @(negedge clk);

        // reset held with a requester valid
        m0_req_valid = 1; m0_req_addr = 32'h100;
        #1;
        chk("rst_ready0", m0_req_ready, 0);
        chk("rst_ram_vld", ram_req_valid, 0);
        tick();
        chk("rst_ram_addr", ram_addr, 0);
        chk("rst_rsp_rdata", m0_rsp_rdata, 0);

        // single aligned read
        rst = 1; ram_req_ready = 1;
        #1;
        chk("rd_ready", m0_req_ready, 1);
        tick();
        m0_req_valid = 0;
        #1;
        chk("rd_ram_vld", ram_req_valid, 1);
        chk("rd_ram_addr", ram_addr, 32'h100);
        tick();
        ram_rsp_valid = 1; ram_rsp_rdata = 32'hDEADBEEF;
        #1;
        chk("rd_not_early", m0_rsp_valid, 0);
        tick();

        // response at t+3; same cycle m1 issues a misaligned write
        ram_rsp_valid = 0;
        m1_req_valid = 1; m1_req_addr = 32'h102; m1_req_we = 1; m1_req_wdata = 32'h12345678; m1_req_be = 4'hF;
        #1;
        chk("rd_rsp_vld", m0_rsp_valid, 1);
        chk("rd_rsp_data", m0_rsp_rdata, 32'hDEADBEEF);
        chk("rd_rsp_err", m0_rsp_err, 0);
        chk("rd_m1_quiet", m1_rsp_valid, 0);
        chk("mis_ready1", m1_req_ready, 1);
        tick();
        m1_req_valid = 0;
        #1;
        chk("mis_no_ram", ram_req_valid, 0);
        tick();

        // misaligned error at t+2; prio flipped back to m0
        m0_req_valid = 1; m0_req_addr = 32'h200; m0_req_we = 0;
        m1_req_valid = 1; m1_req_addr = 32'h204;
        #1;
        chk("mis_rsp_vld", m1_rsp_valid, 1);
        chk("mis_rsp_err", m1_rsp_err, 1);
        chk("mis_rsp_data", m1_rsp_rdata, 0);
        chk("flip_ready0", m0_req_ready, 1);
        chk("flip_ready1", m1_req_ready, 0);
        tick();

        // ram never answers: error 8 cycles after entering ISSUE
        m0_req_valid = 0; m1_req_valid = 0;
        for (int k = 1; k <= 9; k++) begin
            if (k == 9) ram_rsp_valid = 1;
            #1;
            chk("to_rsp_vld", m0_rsp_valid, (k == 9));
            if (k == 9) begin
                chk("to_rsp_err", m0_rsp_err, 1);
                chk("to_rsp_data", m0_rsp_rdata, 0);
            end
            tick();
        end

        // late ram response ignored; start a write under backpressure
        ram_rsp_valid = 0; ram_req_ready = 0;
        m0_req_valid = 1; m0_req_addr = 32'h300; m0_req_we = 1; m0_req_wdata = 32'hA5A51234; m0_req_be = 4'b0011;
        #1;
        chk("late_ignored", m0_rsp_valid, 0);
        chk("late_err_held", m0_rsp_err, 1);
        chk("bp_ready0", m0_req_ready, 1);
        tick();
        m0_req_valid = 0;
        m1_req_valid = 1; m1_req_addr = 32'h400; m1_req_we = 0;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("bp_vld", ram_req_valid, 1);
            chk("bp_addr", ram_addr, 32'h300);
            chk("bp_wdata", ram_wdata, 32'hA5A51234);
            chk("bp_be", ram_be, 4'b0011);
            chk("bp_m1_blocked", m1_req_ready, 0);
            tick();
        end
        ram_req_ready = 1;
        tick();
        ram_rsp_valid = 1; ram_rsp_rdata = 32'h11111111;
        tick();
        ram_rsp_valid = 0; m1_req_valid = 0;
        #1;
        chk("wr_rsp_vld", m0_rsp_valid, 1);
        chk("wr_rsp_data", m0_rsp_rdata, 0);
        chk("wr_rsp_err", m0_rsp_err, 0);
        tick();

        // contention after reset: grants alternate starting with m0
        rst = 0;
        tick();
        rst = 1;
        m0_req_valid = 1; m0_req_addr = 32'h10; m0_req_we = 0;
        m1_req_valid = 1; m1_req_addr = 32'h20; m1_req_we = 0;
        ram_req_ready = 1; ram_rsp_valid = 1; ram_rsp_rdata = 32'hCAFE0000;
        for (int k = 0; k < 12; k++) begin
            #1;
            if (m0_req_ready) gq.push_back(0);
            if (m1_req_ready) gq.push_back(1);
            tick();
        end
        chk("cont_count", gq.size(), 4);
        for (int i = 0; i < gq.size() && i < 4; i++) chk("cont_order", gq[i], i % 2);

        // reset while waiting on ram
        m0_req_valid = 0; m1_req_valid = 0; ram_rsp_valid = 0;
        for (int k = 0; k < 3; k++) tick();
        m0_req_valid = 1; m0_req_addr = 32'h500;
        tick();
        m0_req_valid = 0;
        tick();
        rst = 0; m0_req_valid = 1;
        tick();
        #1;
        chk("rw_rsp_data0", m0_rsp_rdata, 0);
        chk("rw_rsp_data1", m1_rsp_rdata, 0);
        chk("rw_ram_vld", ram_req_valid, 0);
        chk("rw_ready0", m0_req_ready, 0);
        rst = 1; m0_req_valid = 0; ram_rsp_valid = 1;
        tick();
        chk("rw_no_rsp0", m0_rsp_valid, 0);
        chk("rw_no_rsp1", m1_rsp_valid, 0);
        ram_rsp_valid = 0;

        // randomized traffic
        dead = 0;
        for (int k = 0; k < 3000; k++) begin
            if (k % 64 == 0) dead = ($urandom_range(0, 3) == 0);
            rst = ($urandom_range(0, 399) != 0);
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            m0_req_valid = $urandom_range(0, 1); m0_req_addr = a;
            m0_req_wdata = $urandom; m0_req_we = $urandom_range(0, 1); m0_req_be = BW'($urandom);
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            m1_req_valid = $urandom_range(0, 1); m1_req_addr = a;
            m1_req_wdata = $urandom; m1_req_we = $urandom_range(0, 1); m1_req_be = BW'($urandom);
            ram_req_ready = ($urandom_range(0, 99) < 60);
            ram_rsp_valid = !dead && ($urandom_range(0, 99) < 35);
            ram_rsp_rdata = $urandom;
            tick();
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
